// File: rtl/bus_slave_mem.sv
// -----------------------------------------------------------------------------
// bus_slave_mem
//
// Memory-backed responder for one req/ack slave port of the crossbar. It
// accepts a held single-word read or write request, waits a programmable
// number of cycles, pulses ack for one cycle and presents read data in the
// cycle after ack.
//
// Parameters:
//   DEPTH_LOG2  - log2 of memory depth in 32-bit words
//   WAIT_CYCLES - fixed wait states between acceptance and ack (0..15)
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   reset  - synchronous, active-high reset (also clears the memory)
//   req    - transfer request, held by the crossbar until ack
//   addr   - byte address; word index = addr[DEPTH_LOG2+1:2]
//   cmd    - 1 = write, 0 = read
//   wdata  - write data, valid with req when cmd = 1
//   ack    - one-cycle completion pulse
//   rdata  - read data, valid in the cycle after a read ack
//
// Build option:
//   BUS_SLAVE_MEM_RAND_WAIT_EN - when defined, an 8-bit LFSR adds 0..3 extra
//   wait states per transfer on top of WAIT_CYCLES.
// -----------------------------------------------------------------------------
module bus_slave_mem #(
    parameter int DEPTH_LOG2  = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cmd,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [4:0] WAIT_LD = 5'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_q [DEPTH];

    logic                    mem_we;
    logic [DEPTH_LOG2-1:0]   mem_widx;
    logic [31:0]             mem_wdata;
    logic [4:0]              extra;
    logic [DEPTH_LOG2-1:0]   addr_idx;
    logic                    addr_unused;

    assign addr_idx    = addr[DEPTH_LOG2+1:2];
    // Upper address bits and the byte offset alias onto the same word.
    assign addr_unused = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

`ifdef BUS_SLAVE_MEM_RAND_WAIT_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    // Fibonacci LFSR, x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // Extra waits use the value before this acceptance's step.
    assign extra   = {3'b000, lfsr_q[1:0]};
`else
    assign extra   = 5'd0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = wdata_q;
`ifdef BUS_SLAVE_MEM_RAND_WAIT_EN
        lfsr_d    = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    idx_d   = addr_idx;
                    wr_d    = cmd;
                    wdata_d = wdata;
                    cnt_d   = WAIT_LD + extra;
`ifdef BUS_SLAVE_MEM_RAND_WAIT_EN
                    lfsr_d  = {lfsr_q[6:0], lfsr_fb};
`endif
                    if (cnt_d == 5'd0) begin
                        // Zero waits: commit straight from the bus, since
                        // the latched copies only appear after this edge.
                        state_d   = ST_ACK;
                        mem_we    = cmd;
                        mem_widx  = addr_idx;
                        mem_wdata = wdata;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    // Write lands on the same edge that raises ack.
                    state_d = ST_ACK;
                    mem_we  = wr_q;
                end
            end

            ST_ACK: begin
                state_d = ST_RESP;
                if (!wr_q) begin
                    rdata_d = mem_q[idx_q];
                end
            end

            ST_RESP: begin
                // req may still be high here; it is deliberately ignored.
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
`ifdef BUS_SLAVE_MEM_RAND_WAIT_EN
            lfsr_q  <= 8'hA5;
`endif
            // NOTE: the memory must read as zero after reset, so it is built
            // from resettable flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef BUS_SLAVE_MEM_RAND_WAIT_EN
            lfsr_q  <= lfsr_d;
`endif
            if (mem_we) begin
                mem_q[mem_widx] <= mem_wdata;
            end
        end
    end

    assign ack   = (state_q == ST_ACK);
    assign rdata = rdata_q;

endmodule
